fpu_sequencer: RTL and testbench

FPU_SEQUENCER -- requirements
Module: fpu_sequencer

---
 rtl/fpu_sequencer.sv | 117 +++++++++++
 tb/tb_fpu_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fpu_sequencer.sv
`default_nettype none
// ============================================================================
// fpu_sequencer : request/start/exec/response control for a single FPU core
// Rev 1.0
// ============================================================================
module fpu_sequencer #(
  parameter int OPW     = 2,
  parameter int TIMEOUT = 15,
  parameter int CW      = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  input  logic [OPW-1:0] req_op,
  output logic           req_ready,
  output logic           ld_ops,
  output logic [OPW-1:0] fpu_op,
  output logic           fpu_start,
  input  logic           fpu_done,
  output logic           ld_res,
  output logic           rsp_valid,
  output logic           rsp_timeout,
  input  logic           rsp_ready,
  output logic           busy,
  output logic [7:0]     done_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    EXEC  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [CW-1:0] C_TMO_LAST = CW'(TIMEOUT - 1);

  state_t         r_state;
  state_t         w_next;
  logic [CW-1:0]  r_cnt;
  logic [OPW-1:0] r_op;
  logic           r_timeout;
  logic [7:0]     r_done_cnt;

  assign fpu_op      = r_op;
  assign rsp_timeout = r_timeout;
  assign done_cnt    = r_done_cnt;

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    ld_ops    = 1'b0;
    fpu_start = 1'b0;
    ld_res    = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        ld_ops    = req_valid;
        if (req_valid) w_next = START;
      end
      START: begin
        fpu_start = 1'b1;
        w_next    = EXEC;
      end
      EXEC: begin
        // A done arriving on the last allowed cycle still counts as completion
        if (fpu_done) begin
          ld_res = 1'b1;
          w_next = RESP;
        end else if (r_cnt == C_TMO_LAST) begin
          w_next = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_op       <= '0;
      r_timeout  <= 1'b0;
      r_done_cnt <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (req_valid) r_op <= req_op;
        end
        START: begin
          r_cnt <= '0;
        end
        EXEC: begin
          if (fpu_done) begin
            r_timeout <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == C_TMO_LAST) r_timeout <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) r_done_cnt <= r_done_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpu_sequencer.sv
`default_nettype none
// ============================================================================
// tb_fpu_sequencer : scoreboard bench for fpu_sequencer (TIMEOUT=4)
// Rev 1.0
// ============================================================================
module tb_fpu_sequencer;
  localparam int OPW = 2;
  localparam int TMO = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           req_valid = 1'b0;
  logic [OPW-1:0] req_op = '0;
  logic           fpu_done = 1'b0;
  logic           rsp_ready = 1'b0;
  logic           req_ready, ld_ops, fpu_start, ld_res, rsp_valid, rsp_timeout, busy;
  logic [OPW-1:0] fpu_op;
  logic [7:0]     done_cnt;

  int   checks   = 0;
  int   failures = 0;
  logic exp_q[$];
  int   exp_cnt  = 0;

  fpu_sequencer #(.OPW(OPW), .TIMEOUT(TMO), .CW(8)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_ready  (req_ready),
    .ld_ops     (ld_ops),
    .fpu_op     (fpu_op),
    .fpu_start  (fpu_start),
    .fpu_done   (fpu_done),
    .ld_res     (ld_res),
    .rsp_valid  (rsp_valid),
    .rsp_timeout(rsp_timeout),
    .rsp_ready  (rsp_ready),
    .busy       (busy),
    .done_cnt   (done_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got=expired exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // done_at: EXEC cycle index (0-based) carrying fpu_done, negative = never
  task automatic run_op(input logic [OPW-1:0] op, input int done_at, input int hold);
    logic exp_to;
    bit   hs;
    req_valid = 1'b1;
    req_op    = op;
    #1;
    check_eq("accept_ready", 32'(req_ready), 32'd1);
    check_eq("accept_ld_ops", 32'(ld_ops), 32'd1);
    exp_to = (done_at < 0) || (done_at >= TMO);
    exp_q.push_back(exp_to);
    tick();
    req_valid = 1'b0;
    req_op    = ~op;
    #1;
    check_eq("start_pulse", 32'(fpu_start), 32'd1);
    check_eq("start_fpu_op", 32'(fpu_op), 32'(op));
    check_eq("start_busy", 32'(busy), 32'd1);
    check_eq("start_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < TMO; i++) begin
      tick();
      fpu_done = (i == done_at);
      #1;
      check_eq("exec_ld_res", 32'(ld_res), 32'(i == done_at));
      check_eq("exec_no_start", 32'(fpu_start), 32'd0);
      check_eq("exec_no_rsp", 32'(rsp_valid), 32'd0);
      if (i == done_at) break;
    end
    tick();
    fpu_done = 1'b0;
    #1;
    check_eq("resp_valid", 32'(rsp_valid), 32'd1);
    check_eq("resp_timeout", 32'(rsp_timeout), 32'(exp_to));
    check_eq("resp_ld_res", 32'(ld_res), 32'd0);
    for (int i = 0; i < hold; i++) begin
      fpu_done  = 1'b1;
      req_valid = 1'b1;
      rsp_ready = 1'b0;
      #1;
      check_eq("bp_valid", 32'(rsp_valid), 32'd1);
      check_eq("bp_timeout", 32'(rsp_timeout), 32'(exp_to));
      check_eq("bp_ready", 32'(req_ready), 32'd0);
      check_eq("bp_ld_ops", 32'(ld_ops), 32'd0);
      check_eq("bp_ld_res", 32'(ld_res), 32'd0);
      tick();
    end
    fpu_done  = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    #1;
    hs = 1'b0;
    for (int n = 0; n < 20 && !hs; n++) begin
      if (rsp_valid) begin
        hs = 1'b1;
        if (exp_q.size() > 0) check_eq("sb_timeout", 32'(rsp_timeout), 32'(exp_q.pop_front()));
        else check_eq("sb_underflow", 32'd1, 32'd0);
      end
      tick();
    end
    if (hs) exp_cnt = (exp_cnt + 1) % 256;
    else check_eq("rsp_wait", 32'd0, 32'd1);
    rsp_ready = 1'b0;
    #1;
    check_eq("done_cnt", 32'(done_cnt), 32'(exp_cnt));
    check_eq("post_idle_busy", 32'(busy), 32'd0);
    check_eq("post_idle_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    req_valid = 1'b1;
    #2;
    check_eq("rst_ready", 32'(req_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_start", 32'(fpu_start), 32'd0);
    check_eq("rst_ld_res", 32'(ld_res), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_ld_ops", 32'(ld_ops), 32'd1);
    check_eq("rst_fpu_op", 32'(fpu_op), 32'd0);
    check_eq("rst_timeout", 32'(rsp_timeout), 32'd0);
    check_eq("rst_done_cnt", 32'(done_cnt), 32'd0);
    req_valid = 1'b0;
    #1;
    check_eq("rst_ld_ops_low", 32'(ld_ops), 32'd0);
    repeat (2) tick();
    rst = 1'b1;

    // stray done while idle
    fpu_done = 1'b1;
    #1;
    check_eq("idle_done_ld_res", 32'(ld_res), 32'd0);
    tick();
    check_eq("idle_done_busy", 32'(busy), 32'd0);
    check_eq("idle_done_rsp", 32'(rsp_valid), 32'd0);
    fpu_done = 1'b0;

    run_op(2'd2, 1, 0);       // nominal
    run_op(2'd1, -1, 0);      // timeout
    run_op(2'd3, TMO - 1, 0); // done collides with expiry
    run_op(2'd0, 0, 5);       // backpressure, normal response
    run_op(2'd1, -1, 3);      // backpressure, timeout response

    // asynchronous reset during EXEC
    req_valid = 1'b1;
    req_op    = 2'd3;
    #1;
    tick();
    req_valid = 1'b0;
    tick();
    #1;
    check_eq("mid_busy_before", 32'(busy), 32'd1);
    rst      = 1'b0;
    fpu_done = 1'b1;
    #1;
    check_eq("arst_ready", 32'(req_ready), 32'd1);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("arst_ld_res", 32'(ld_res), 32'd0);
    check_eq("arst_done_cnt", 32'(done_cnt), 32'd0);
    check_eq("arst_fpu_op", 32'(fpu_op), 32'd0);
    exp_cnt = 0;
    tick();
    rst = 1'b1;
    #1;
    check_eq("late_done_ld_res", 32'(ld_res), 32'd0);
    tick();
    check_eq("late_done_busy", 32'(busy), 32'd0);
    check_eq("late_done_rsp", 32'(rsp_valid), 32'd0);
    fpu_done = 1'b0;

    for (int i = 0; i < 256; i++) begin
      run_op(OPW'(i), i % TMO, 0);
    end
    check_eq("wrap_zero", 32'(done_cnt), 32'd0);
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
